// File: rtl/calc_core_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : calc_core_seq                                              |
// | Description : Sequential BCD arithmetic core for the keypad calculator.  |
// |               Captures two DIGITS-digit BCD operands and a one-hot op,   |
// |               converts them to binary, performs add / sub / mul /        |
// |               rounded div and converts the result back to BCD with a     |
// |               fixed latency of DIGITS + 2*RES_W + 1 cycles.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   1          system clock                                |
// |   rst        in   1          synchronous active-high reset               |
// |   a_bcd      in   4*DIGITS   operand A, BCD, MSD in top nibble           |
// |   b_bcd      in   4*DIGITS   operand B, BCD                              |
// |   op         in   4          0001 add, 0010 sub, 0100 mul, 1000 div      |
// |   start      in   1          request, sampled only in IDLE               |
// |   busy       out  1          operation in progress (CONV..DONE)          |
// |   done       out  1          one-cycle pulse, result valid               |
// |   result_bcd out  8*DIGITS   |result| in BCD                             |
// |   negative   out  1          subtraction with A < B                      |
// |   err        out  1          div by zero, bad op or invalid BCD nibble   |
// +--------------------------------------------------------------------------+
module calc_core_seq #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  input  logic [3:0]            op,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [8*DIGITS-1:0]   result_bcd,
  output logic                  negative,
  output logic                  err
);

  localparam int BIN_W = $clog2(10**DIGITS);
  localparam int RES_W = 2*BIN_W;
  localparam int REM_W = RES_W + 1;
  localparam int CNT_W = $clog2(RES_W);
  localparam int OPD_W = 4*DIGITS;
  localparam int BCD_W = 8*DIGITS;

  localparam logic [3:0]       c_opAdd    = 4'b0001;
  localparam logic [3:0]       c_opSub    = 4'b0010;
  localparam logic [3:0]       c_opMul    = 4'b0100;
  localparam logic [3:0]       c_opDiv    = 4'b1000;
  localparam logic [BIN_W-1:0] c_ten      = BIN_W'(10);
  localparam logic [CNT_W-1:0] c_convLast = CNT_W'(DIGITS-1);
  localparam logic [CNT_W-1:0] c_resLast  = CNT_W'(RES_W-1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_CALC = 3'd2,
    S_BCD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [CNT_W-1:0]    r_cnt;

  // Captured operands; the BCD copies shift left one digit per CONV cycle.
  logic [OPD_W-1:0]    r_aBcd;
  logic [OPD_W-1:0]    r_bBcd;
  logic [3:0]          r_op;
  logic                r_err;
  logic [BIN_W-1:0]    r_binA;
  logic [BIN_W-1:0]    r_binB;

  // r_res is the working register: product, dividend/quotient, and finally
  // the binary source that double-dabble shifts out of its top bit.
  logic [RES_W-1:0]    r_res;
  logic [RES_W-1:0]    r_mcand;
  logic [BIN_W-1:0]    r_mplier;
  logic [RES_W-1:0]    r_rem;
  logic                r_neg;
  logic [BCD_W-1:0]    r_bcd;

  logic                w_nibBad;
  logic                w_opBad;
  logic                w_divZero;
  logic                w_capErr;
  logic [3:0]          w_digA;
  logic [3:0]          w_digB;
  logic [BIN_W-1:0]    w_nextA;
  logic [BIN_W-1:0]    w_nextB;
  logic [RES_W-1:0]    w_dividend;
  logic [REM_W-1:0]    w_divisor;
  logic [REM_W-1:0]    w_remSh;
  logic                w_divFit;
  logic [BCD_W-1:0]    w_ddAdj;
  logic [BCD_W-1:0]    w_ddBcd;

  // ---------------------------------------------------------------------
  // Error detection on the raw inputs, used only on the capture cycle
  // ---------------------------------------------------------------------
  always_comb begin
    w_nibBad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a_bcd[4*i +: 4] > 4'd9) || (b_bcd[4*i +: 4] > 4'd9)) begin
        w_nibBad = 1'b1;
      end
    end
  end

  assign w_opBad   = !((op == c_opAdd) || (op == c_opSub) ||
                       (op == c_opMul) || (op == c_opDiv));
  assign w_divZero = (op == c_opDiv) && (b_bcd == '0);
  assign w_capErr  = w_nibBad || w_opBad || w_divZero;

  // ---------------------------------------------------------------------
  // BCD -> binary: acc = acc*10 + digit. Arithmetic is modulo 2^BIN_W,
  // which is exact because every valid intermediate value fits.
  // ---------------------------------------------------------------------
  assign w_digA     = r_aBcd[OPD_W-1 -: 4];
  assign w_digB     = r_bBcd[OPD_W-1 -: 4];
  assign w_nextA    = r_binA * c_ten + BIN_W'(w_digA);
  assign w_nextB    = r_binB * c_ten + BIN_W'(w_digB);

  // Rounded division q = (2A+B) / (2B)
  assign w_dividend = RES_W'({w_nextA, 1'b0}) + RES_W'(w_nextB);
  assign w_divisor  = REM_W'({r_binB, 1'b0});
  assign w_remSh    = {r_rem, r_res[RES_W-1]};
  assign w_divFit   = (w_remSh >= w_divisor);

  // ---------------------------------------------------------------------
  // Double-dabble step: add 3 to every nibble >= 5, then shift in the next
  // binary bit. The top bit of the adjusted value is always zero because
  // the result fits in 2*DIGITS digits, so it is dropped.
  // ---------------------------------------------------------------------
  always_comb begin
    w_ddAdj = r_bcd;
    for (int i = 0; i < 2*DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_ddAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_ddBcd = BCD_W'({w_ddAdj, r_res[RES_W-1]});

  // ---------------------------------------------------------------------
  // FSM: state register and phase counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_stateNext != r_state) begin
        r_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // FSM: next state and status outputs
  always_comb begin
    w_stateNext = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_stateNext = S_CONV;
        end
      end
      S_CONV: begin
        busy = 1'b1;
        if (r_cnt == c_convLast) begin
          w_stateNext = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == c_resLast) begin
          w_stateNext = S_BCD;
        end
      end
      S_BCD: begin
        busy = 1'b1;
        if (r_cnt == c_resLast) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aBcd     <= '0;
      r_bBcd     <= '0;
      r_op       <= '0;
      r_err      <= 1'b0;
      r_binA     <= '0;
      r_binB     <= '0;
      r_res      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_rem      <= '0;
      r_neg      <= 1'b0;
      r_bcd      <= '0;
      result_bcd <= '0;
      negative   <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_aBcd <= a_bcd;
            r_bBcd <= b_bcd;
            r_op   <= op;
            r_err  <= w_capErr;
            r_binA <= '0;
            r_binB <= '0;
            r_neg  <= 1'b0;
          end
        end

        S_CONV: begin
          r_aBcd   <= r_aBcd << 4;
          r_bBcd   <= r_bBcd << 4;
          r_binA   <= w_nextA;
          r_binB   <= w_nextB;
          // Operation setup is rewritten every CONV cycle; the values from
          // the last digit are the ones that reach CALC.
          r_mcand  <= RES_W'(w_nextA);
          r_mplier <= w_nextB;
          r_rem    <= '0;
          r_res    <= (r_op == c_opDiv) ? w_dividend : '0;
        end

        S_CALC: begin
          r_bcd <= '0;
          if (r_op == c_opAdd) begin
            if (r_cnt == '0) begin
              r_res <= RES_W'(r_binA) + RES_W'(r_binB);
            end
          end else if (r_op == c_opSub) begin
            if (r_cnt == '0) begin
              if (r_binA < r_binB) begin
                r_res <= RES_W'(r_binB - r_binA);
                r_neg <= 1'b1;
              end else begin
                r_res <= RES_W'(r_binA - r_binB);
                r_neg <= 1'b0;
              end
            end
          end else if (r_op == c_opMul) begin
            // Multiplier drains to zero after BIN_W cycles, so the
            // remaining cycles leave the product unchanged.
            if (r_mplier[0]) begin
              r_res <= r_res + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end else if (r_op == c_opDiv) begin
            // Restoring division over the zero-extended dividend: the
            // quotient bits shift in from the right as the dividend
            // shifts out of the top into the remainder.
            if (w_divFit) begin
              r_rem <= RES_W'(w_remSh - w_divisor);
            end else begin
              r_rem <= RES_W'(w_remSh);
            end
            r_res <= {r_res[RES_W-2:0], w_divFit};
          end
        end

        S_BCD: begin
          r_bcd <= w_ddBcd;
          r_res <= r_res << 1;
          if (r_cnt == c_resLast) begin
            result_bcd <= r_err ? '0 : w_ddBcd;
            negative   <= r_err ? 1'b0 : r_neg;
            err        <= r_err;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_core_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_calc_core_seq                                           |
// | Description : Self-checking bench for calc_core_seq (DIGITS = 2).        |
// |               Vector table plus hand-written multi-cycle sequences;      |
// |               expected results travel through a scoreboard queue.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_calc_core_seq;

  localparam int DIGITS = 2;

  typedef struct {
    logic [15:0] res;
    logic        neg;
    logic        err;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  op;
    logic [15:0] res;
    logic        neg;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_bcd;
  logic [7:0]  b_bcd;
  logic [3:0]  op;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] result_bcd;
  logic        negative;
  logic        err;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  exp_t prev;

  always #5 clk = ~clk;

  calc_core_seq #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_bcd      (a_bcd),
    .b_bcd      (b_bcd),
    .op         (op),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .result_bcd (result_bcd),
    .negative   (negative),
    .err        (err)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference arithmetic for random vectors, from integer math.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] o);
    exp_t e;
    int   ai, bi, r;
    e.res = '0; e.neg = 1'b0; e.err = 1'b0;
    ai = int'(a[7:4]) * 10 + int'(a[3:0]);
    bi = int'(b[7:4]) * 10 + int'(b[3:0]);
    if (a[7:4] > 9 || a[3:0] > 9 || b[7:4] > 9 || b[3:0] > 9 ||
        !(o inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}) || (o == 4'b1000 && bi == 0)) begin
      e.err = 1'b1;
      return e;
    end
    case (o)
      4'b0001: r = ai + bi;
      4'b0010: begin r = (ai >= bi) ? ai - bi : bi - ai; e.neg = (ai < bi); end
      4'b0100: r = ai * bi;
      default: r = (2*ai + bi) / (2*bi);
    endcase
    e.res = toBcd(r);
    return e;
  endfunction

  task automatic scoreDone(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: done with empty scoreboard, result %0h", tag, result_bcd);
    end else begin
      e = sbq.pop_front();
      check({tag, " result"},   32'(result_bcd), 32'(e.res));
      check({tag, " negative"}, 32'(negative),   32'(e.neg));
      check({tag, " err"},      32'(err),        32'(e.err));
      prev = e;
    end
  endtask

  // One operation: start at cycle 0, expect done at cycle 31.
  task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] o,
                       input exp_t e, input string tag, input int restartAt, input bit startOnDone);
    int cyc;
    @(negedge clk);
    a_bcd = a; b_bcd = b; op = o; start = 1'b1;
    sbq.push_back(e);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        a_bcd = 8'h00; b_bcd = 8'h00; op = 4'b1000;
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " hold"}, 32'({result_bcd, negative, err}), 32'({prev.res, prev.neg, prev.err}));
      end
      if (restartAt > 0 && cyc == restartAt) begin
        a_bcd = 8'h99; b_bcd = 8'h99; op = 4'b0100; start = 1'b1;
      end
      if (restartAt > 0 && cyc == restartAt + 1) start = 1'b0;
    end while (!done && cyc < 100);
    check({tag, " latency"}, 32'(cyc), 32'd31);
    if (done) scoreDone(tag);
    else void'(sbq.pop_front());
    if (startOnDone) begin
      a_bcd = 8'h11; b_bcd = 8'h22; op = 4'b0001; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, " pulse"}, 32'({done, busy}), 32'd0);
  endtask

  task automatic idleWindow(input int n, input string tag);
    int dones;
    dones = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) dones++;
    end
    check({tag, " no done"}, 32'(dones), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  vec_t tbl[16];

  initial begin
    int   cyc;
    exp_t e;
    logic [7:0] ra, rb;
    logic [3:0] ro;

    tbl[0]  = '{8'h45, 8'h37, 4'b0001, 16'h0082, 1'b0, 1'b0};
    tbl[1]  = '{8'h12, 8'h57, 4'b0010, 16'h0045, 1'b1, 1'b0};
    tbl[2]  = '{8'h33, 8'h33, 4'b0010, 16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{8'h99, 8'h99, 4'b0100, 16'h9801, 1'b0, 1'b0};
    tbl[4]  = '{8'h07, 8'h02, 4'b1000, 16'h0004, 1'b0, 1'b0};
    tbl[5]  = '{8'h10, 8'h03, 4'b1000, 16'h0003, 1'b0, 1'b0};
    tbl[6]  = '{8'h05, 8'h00, 4'b1000, 16'h0000, 1'b0, 1'b1};
    tbl[7]  = '{8'h45, 8'h37, 4'b0011, 16'h0000, 1'b0, 1'b1};
    tbl[8]  = '{8'h1A, 8'h02, 4'b0001, 16'h0000, 1'b0, 1'b1};
    tbl[9]  = '{8'h99, 8'h99, 4'b0001, 16'h0198, 1'b0, 1'b0};
    tbl[10] = '{8'h00, 8'h99, 4'b0010, 16'h0099, 1'b1, 1'b0};
    tbl[11] = '{8'h99, 8'h01, 4'b1000, 16'h0099, 1'b0, 1'b0};
    tbl[12] = '{8'h50, 8'h07, 4'b0100, 16'h0350, 1'b0, 1'b0};
    tbl[13] = '{8'h01, 8'h03, 4'b1000, 16'h0000, 1'b0, 1'b0};
    tbl[14] = '{8'h12, 8'h9F, 4'b0100, 16'h0000, 1'b0, 1'b1};
    tbl[15] = '{8'h88, 8'h11, 4'b0000, 16'h0000, 1'b0, 1'b1};

    prev  = '{16'h0000, 1'b0, 1'b0};
    rst   = 1'b1;
    start = 1'b0;
    a_bcd = '0; b_bcd = '0; op = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", 32'({busy, done, result_bcd, negative, err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset idle", 32'({busy, done, result_bcd, negative, err}), 32'd0);

    for (int i = 0; i < 16; i++) begin
      e = '{tbl[i].res, tbl[i].neg, tbl[i].err};
      runOp(tbl[i].a, tbl[i].b, tbl[i].op, e, $sformatf("vec%0d", i), -1, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      ro = 4'(4'b0001 << $urandom_range(0, 3));
      runOp(ra, rb, ro, model(ra, rb, ro), $sformatf("rnd%0d", i), -1, 1'b0);
    end

    // start while busy is ignored
    runOp(8'h45, 8'h37, 4'b0001, '{16'h0082, 1'b0, 1'b0}, "busy-start", 10, 1'b0);
    idleWindow(40, "busy-start");

    // start coinciding with DONE is not sampled
    runOp(8'h12, 8'h34, 4'b0001, '{16'h0046, 1'b0, 1'b0}, "done-start", -1, 1'b1);
    idleWindow(40, "done-start");
    check("done-start hold", 32'(result_bcd), 32'h0046);

    // reset in the middle of a multiply
    @(negedge clk);
    a_bcd = 8'h99; b_bcd = 8'h99; op = 4'b0100; start = 1'b1;
    cyc = 0;
    while (cyc < 15) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    check("pre-abort busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort outputs", 32'({busy, done, result_bcd, negative, err}), 32'd0);
    rst = 1'b0;
    prev = '{16'h0000, 1'b0, 1'b0};
    idleWindow(40, "abort");
    runOp(8'h12, 8'h34, 4'b0100, '{16'h0408, 1'b0, 1'b0}, "post-abort", -1, 1'b0);

    check("scoreboard empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
